lab4d_serial_writer: RTL and testbench

LAB4D_SERIAL_WRITER -- requirements
Module: lab4d_serial_writer

---
 rtl/lab4d_pkg.sv | 16 +
 rtl/lab4d_phase_timer.sv | 27 ++
 rtl/lab4d_serial_writer.sv | 159 +++++++++++++++
 tb/tb_lab4d_serial_writer.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/lab4d_pkg.sv
// Shared constants and state encoding for the LAB4D serial configuration writer.
package lab4d_pkg;
  localparam int unsigned NUM_LAB4    = 12;
  localparam int unsigned SERIAL_BITS = 24;
  localparam int unsigned PRESCALE_W  = 8;
  localparam int unsigned SEL_W       = 4;

  localparam logic [SEL_W-1:0] BROADCAST_SEL = 4'hF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOW   = 2'd1,
    HIGH  = 2'd2,
    LATCH = 2'd3
  } state_t;
endpackage

// File: rtl/lab4d_phase_timer.sv
// Prescale phase counter: loads P, counts down to zero, flags the last cycle of a phase.
module lab4d_phase_timer
  import lab4d_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  load_i,
  input  logic [PRESCALE_W-1:0] prescale_i,
  output logic                  phase_end_c
);

  logic [PRESCALE_W-1:0] cnt;

  // Saturates at zero so an idle timer never wraps.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt <= '0;
    end else if (load_i) begin
      cnt <= prescale_i;
    end else if (cnt != '0) begin
      cnt <= cnt - PRESCALE_W'(1);
    end
  end

  assign phase_end_c = (cnt == '0);

endmodule

// File: rtl/lab4d_serial_writer.sv
// Serial word writer for a bank of LAB4D chips (SIN/SCLK/PCLK per chip).
// Optional SHOUT readback capture is built when LAB4D_SERIAL_READBACK_EN is defined.
module lab4d_serial_writer
  import lab4d_pkg::*;
#(
  parameter int unsigned NUM_LAB4    = lab4d_pkg::NUM_LAB4,
  parameter int unsigned SERIAL_BITS = lab4d_pkg::SERIAL_BITS
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   go_i,
  input  logic [SERIAL_BITS-1:0] word_i,
  input  logic [SEL_W-1:0]       select_i,
  input  logic [PRESCALE_W-1:0]  prescale_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   err_o,
  output logic [NUM_LAB4-1:0]    SIN,
  output logic [NUM_LAB4-1:0]    SCLK,
  output logic [NUM_LAB4-1:0]    PCLK,
  input  logic [NUM_LAB4-1:0]    SHOUT,
  output logic [SERIAL_BITS-1:0] readback_o
);

  localparam int unsigned BIT_W = (SERIAL_BITS > 1) ? $clog2(SERIAL_BITS) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(SERIAL_BITS - 1);

  state_t                  state, state_n;
  logic [SERIAL_BITS-1:0]  shreg, shreg_n;
  logic [SEL_W-1:0]        sel_q, sel_n;
  logic [PRESCALE_W-1:0]   pre_q, pre_n, load_p;
  logic [BIT_W-1:0]        bit_cnt, bit_cnt_n;
  logic [NUM_LAB4-1:0]     mask_n;
  logic                    sel_valid, accept, load, phase_end_c;
  logic                    done_n, err_n, sin_n, sclk_n, pclk_n;

  lab4d_phase_timer u_timer (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .load_i      (load),
    .prescale_i  (load_p),
    .phase_end_c (phase_end_c)
  );

  assign sel_valid = (select_i == BROADCAST_SEL) || (32'(select_i) < NUM_LAB4);

  // Next-state, datapath and next pin values.
  always_comb begin
    state_n   = state;
    shreg_n   = shreg;
    sel_n     = sel_q;
    pre_n     = pre_q;
    bit_cnt_n = bit_cnt;
    accept    = 1'b0;
    load      = 1'b0;
    done_n    = 1'b0;
    err_n     = 1'b0;
    unique case (state)
      IDLE: begin
        if (go_i) begin
          if (sel_valid) begin
            accept    = 1'b1;
            load      = 1'b1;
            state_n   = LOW;
            shreg_n   = word_i;
            sel_n     = select_i;
            pre_n     = prescale_i;
            bit_cnt_n = '0;
          end else begin
            err_n = 1'b1;
          end
        end
      end
      LOW: begin
        if (phase_end_c) begin
          load    = 1'b1;
          state_n = HIGH;
        end
      end
      HIGH: begin
        if (phase_end_c) begin
          load = 1'b1;
          if (bit_cnt == LAST_BIT) begin
            state_n = LATCH;
          end else begin
            state_n   = LOW;
            bit_cnt_n = bit_cnt + BIT_W'(1);
            shreg_n   = {shreg[SERIAL_BITS-2:0], 1'b0};
          end
        end
      end
      LATCH: begin
        if (phase_end_c) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    load_p = accept ? prescale_i : pre_q;
    sin_n  = ((state_n == LOW) || (state_n == HIGH)) && shreg_n[SERIAL_BITS-1];
    sclk_n = (state_n == HIGH);
    pclk_n = (state_n == LATCH);
    for (int unsigned i = 0; i < NUM_LAB4; i++) begin
      mask_n[i] = (sel_n == BROADCAST_SEL) || (32'(sel_n) == i);
    end
  end

  // State register plus registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      shreg   <= '0;
      sel_q   <= '0;
      pre_q   <= '0;
      bit_cnt <= '0;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
      err_o   <= 1'b0;
      SIN     <= '0;
      SCLK    <= '0;
      PCLK    <= '0;
    end else begin
      state   <= state_n;
      shreg   <= shreg_n;
      sel_q   <= sel_n;
      pre_q   <= pre_n;
      bit_cnt <= bit_cnt_n;
      busy_o  <= (state_n != IDLE);
      done_o  <= done_n;
      err_o   <= err_n;
      SIN     <= {NUM_LAB4{sin_n}} & mask_n;
      SCLK    <= {NUM_LAB4{sclk_n}} & mask_n;
      PCLK    <= {NUM_LAB4{pclk_n}} & mask_n;
    end
  end

`ifdef LAB4D_SERIAL_READBACK_EN
  logic [SEL_W-1:0] rb_idx;

  assign rb_idx = (sel_q == BROADCAST_SEL) ? '0 : sel_q;

  // SHOUT is sampled at the end of each HIGH phase, first sample lands in the MSB.
  always_ff @(posedge clk_i) begin
    if (rst_i || accept) begin
      readback_o <= '0;
    end else if ((state == HIGH) && phase_end_c) begin
      readback_o <= {readback_o[SERIAL_BITS-2:0], SHOUT[rb_idx]};
    end
  end
`else
  logic unused_shout;

  assign unused_shout = ^SHOUT;
  assign readback_o   = '0;
`endif

endmodule

// File: tb/tb_lab4d_serial_writer.sv
// Directed bench for lab4d_serial_writer: vector table plus reset/error/overlap sequences.
module tb_lab4d_serial_writer;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        go_i;
  logic [23:0] word_i;
  logic [3:0]  select_i;
  logic [7:0]  prescale_i;
  logic        busy_o, done_o, err_o;
  logic [11:0] sin, sclk, pclk, shout;
  logic [23:0] readback_o;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0]  pre;
    logic [3:0]  sel;
    logic [23:0] word;
    int          chip;
    logic [11:0] mask;
    int          exp_busy;
    int          exp_phase;
    int          poke_at;
  } vec_t;

  vec_t vecs[5];

  always #5 clk = ~clk;

  assign shout = sin;

  lab4d_serial_writer dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .go_i       (go_i),
    .word_i     (word_i),
    .select_i   (select_i),
    .prescale_i (prescale_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .err_o      (err_o),
    .SIN        (sin),
    .SCLK       (sclk),
    .PCLK       (pclk),
    .SHOUT      (shout),
    .readback_o (readback_o)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge; issues go_i now and monitors the whole transaction.
  task automatic run_vec(input vec_t v);
    int busy_n = 0, edges = 0, pclk_n = 0, stray = 0, run = 0, run_bad = 0, cyc = 0;
    logic [23:0] cap = '0;
    logic [23:0] exp_rb;
    logic prev = 1'b0;
    logic s;
`ifdef LAB4D_SERIAL_READBACK_EN
    exp_rb = v.word;
`else
    exp_rb = '0;
`endif
    go_i = 1'b1; word_i = v.word; select_i = v.sel; prescale_i = v.pre;
    @(negedge clk);
    go_i = 1'b0;
    while (!done_o && cyc < 49 * 256 + 20) begin
      if (busy_o) busy_n++;
      if (err_o) stray++;
      if (((sin | sclk | pclk) & ~v.mask) != 12'h000) stray++;
      if (sclk != 12'h000 && sclk != v.mask) stray++;
      if (sin != 12'h000 && sin != v.mask) stray++;
      if (pclk != 12'h000 && pclk != v.mask) stray++;
      s = sclk[v.chip];
      if (s && !prev) begin
        cap = {cap[22:0], sin[v.chip]};
        edges++;
      end
      if (s) run++;
      else if (prev) begin
        if (run != v.exp_phase) run_bad++;
        run = 0;
      end
      prev = s;
      if (pclk[v.chip]) pclk_n++;
      if (cyc == 0) begin
        word_i = ~v.word;
        prescale_i = v.pre + 8'd3;
      end
      if (cyc == v.poke_at) begin
        go_i = 1'b1; select_i = 4'd5;
      end else begin
        go_i = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    go_i = 1'b0;
    chk("done", done_o, 1);
    chk("busy_at_done", busy_o, 0);
    chk("busy_cycles", busy_n, v.exp_busy);
    chk("word", cap, v.word);
    chk("sclk_edges", edges, 24);
    chk("pclk_len", pclk_n, v.exp_phase);
    chk("high_len", run_bad, 0);
    chk("stray_pins", stray, 0);
    chk("readback", readback_o, exp_rb);
  endtask

  initial begin
    int n_pclk, n_done, n_busy;
    vecs[0] = '{8'd0,   4'd3,  24'hA5C3F0, 3,  12'h008, 49,    1,   10};
    vecs[1] = '{8'd4,   4'hF,  24'h000001, 0,  12'hFFF, 245,   5,   -1};
    vecs[2] = '{8'd1,   4'd0,  24'h800000, 0,  12'h001, 98,    2,   -1};
    vecs[3] = '{8'd2,   4'd11, 24'h5A5A5A, 11, 12'h800, 147,   3,   40};
    vecs[4] = '{8'd255, 4'd7,  24'hFFFFFF, 7,  12'h080, 12544, 256, -1};

    // Reset with go_i held high: must be ignored.
    rst_i = 1'b1; go_i = 1'b1; word_i = 24'hFFFFFF; select_i = 4'd3; prescale_i = 8'd0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy", busy_o, 0);
    chk("rst_flags", {done_o, err_o}, 0);
    chk("rst_pins", {sin, sclk, pclk}, 0);
    chk("rst_readback", readback_o, 0);
    rst_i = 1'b0; go_i = 1'b0;
    @(negedge clk);
    chk("post_rst_busy", busy_o, 0);

    // Table vectors; vec0 chains straight into vec1 from its done cycle.
    run_vec(vecs[0]);
    run_vec(vecs[1]);
    for (int i = 2; i < 5; i++) begin
      @(negedge clk);
      chk("done_single", done_o, 0);
      run_vec(vecs[i]);
    end
    @(negedge clk);
    chk("idle_busy", busy_o, 0);

    // Invalid selects produce a single err_o pulse and nothing else.
    for (int s = 12; s <= 14; s++) begin
      go_i = 1'b1; select_i = 4'(s);
      @(negedge clk);
      go_i = 1'b0;
      chk("err_pulse", err_o, 1);
      chk("err_busy", busy_o, 0);
      chk("err_pins", {sin, sclk, pclk}, 0);
      @(negedge clk);
      chk("err_clear", err_o, 0);
    end

    // Reset at cycle 20 of a P=0 transaction aborts it cleanly.
    go_i = 1'b1; select_i = 4'd3; word_i = 24'hA5C3F0; prescale_i = 8'd0;
    n_pclk = 0; n_done = 0; n_busy = 0;
    @(negedge clk);
    go_i = 1'b0;
    repeat (19) begin
      if (pclk != 12'h000) n_pclk++;
      @(negedge clk);
    end
    chk("abort_busy_before", busy_o, 1);
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    chk("abort_busy", busy_o, 0);
    chk("abort_flags", {done_o, err_o}, 0);
    chk("abort_pins", {sin, sclk, pclk}, 0);
    chk("abort_readback", readback_o, 0);
    repeat (60) begin
      @(negedge clk);
      if (pclk != 12'h000) n_pclk++;
      if (done_o) n_done++;
      if (busy_o) n_busy++;
    end
    chk("abort_pclk", n_pclk, 0);
    chk("abort_done", n_done, 0);
    chk("abort_idle", n_busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
